// File: rtl/polar_sc_decoder.sv
// rtl/polar_sc_decoder.sv - node-parallel min-sum successive-cancellation polar decoder
module polar_sc_decoder #(
    parameter int          N           = 8,
    parameter int          DATA_WIDTH  = 6,
    parameter logic [N-1:0] FROZEN_MASK = 8'h17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATA_WIDTH-1:0] llr_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N-1:0]          u_hat,
    output logic                  out_valid,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int NL = $clog2(N);
    localparam int SW = $clog2(2 * N);
    localparam int H  = N / 2;

    typedef logic signed [W-1:0] llr_t;
    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    localparam llr_t LLR_MIN = {1'b1, {(W-1){1'b0}}};
    localparam llr_t LLR_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic signed [W:0] SAT_POS = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] SAT_NEG = {2'b11, {(W-2){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q;
    logic [NL-1:0]    leaf_q, lvl_q, leaf_nxt, ctz_nxt;
    logic             g_q;
    llr_t             ch_q  [N];
    // Levels 0..NL-1 packed as mem_q[2^l +: 2^l]; entry 0 is never used.
    llr_t             mem_q [N];
    llr_t             la [H];
    llr_t             lb [H];
    llr_t             res [H];
    logic [H-1:0]     sbit;
    logic [N-1:0]     ps [NL];
    logic [N-1:0]     u_dec_q, u_dec_nxt, u_hat_q;
    logic [NL:0]      m;
    logic             bit_dec, accept, last_step;

    function automatic llr_t clamp(input llr_t v);
        return (v == LLR_MIN) ? LLR_NEG : v;
    endfunction

    function automatic llr_t f_op(input llr_t a, input llr_t b);
        llr_t ma, mb, mn;
        ma = a[W-1] ? -a : a;
        mb = b[W-1] ? -b : b;
        mn = (ma < mb) ? ma : mb;
        return (a[W-1] ^ b[W-1]) ? -mn : mn;
    endfunction

    function automatic llr_t g_op(input llr_t a, input llr_t b, input logic s);
        logic signed [W:0] ae, be, sum;
        ae  = {a[W-1], a};
        be  = {b[W-1], b};
        sum = s ? (be - ae) : (be + ae);
        if (sum > SAT_POS) return SAT_POS[W-1:0];
        if (sum < SAT_NEG) return SAT_NEG[W-1:0];
        return sum[W-1:0];
    endfunction

    always_comb begin
        // ps[l] holds every aligned 2^l block of decided bits re-encoded with F^{(x)l}
        ps[0] = u_dec_q;
        for (int l = 1; l < NL; l++) begin
            for (int b = 0; b < N; b += (2 << (l - 1))) begin
                for (int j = 0; j < (1 << (l - 1)); j++) begin
                    ps[l][b + j]                = ps[l-1][b + j] ^ ps[l-1][b + j + (1 << (l - 1))];
                    ps[l][b + j + (1 << (l - 1))] = ps[l-1][b + j + (1 << (l - 1))];
                end
            end
        end
        m = (NL + 1)'(1) << lvl_q;
        for (int j = 0; j < H; j++) begin
            if (lvl_q == NL'(NL - 1)) begin
                la[j] = ch_q[NL'(j)];
                lb[j] = ch_q[NL'(j + int'(m))];
            end else begin
                la[j] = mem_q[NL'(2 * int'(m) + j)];
                lb[j] = mem_q[NL'(3 * int'(m) + j)];
            end
            sbit[j] = ps[lvl_q][NL'(int'(leaf_q) - int'(m) + j)];
            res[j]  = g_q ? g_op(la[j], lb[j], sbit[j]) : f_op(la[j], lb[j]);
        end
        bit_dec             = !FROZEN_MASK[leaf_q] && res[0][W-1];
        u_dec_nxt           = u_dec_q;
        u_dec_nxt[leaf_q]   = bit_dec;
        leaf_nxt            = leaf_q + NL'(1);
        ctz_nxt             = '0;
        for (int k = NL - 1; k >= 0; k--) begin
            if (leaf_nxt[k]) ctz_nxt = NL'(k);
        end
        last_step = (step_q == SW'(2 * N - 3));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q != DECODE) && !rst;
        accept    = in_valid && in_ready;
        out_valid = (state_q == DONE);
        busy      = (state_q == DECODE);
        u_hat     = u_hat_q;
        case (state_q)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  if (last_step) state_d = DONE;
            DONE:    state_d = accept ? DECODE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            leaf_q  <= '0;
            lvl_q   <= '0;
            g_q     <= 1'b0;
            u_dec_q <= '0;
            u_hat_q <= '0;
            for (int i = 0; i < N; i++) begin
                ch_q[i]  <= '0;
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) ch_q[i] <= clamp(llr_in[i*W +: W]);
            step_q  <= '0;
            leaf_q  <= '0;
            lvl_q   <= NL'(NL - 1);
            g_q     <= 1'b0;
            u_dec_q <= '0;
        end else if (state_q == DECODE) begin
            step_q <= step_q + SW'(1);
            for (int j = 0; j < H; j++) begin
                if (j < int'(m)) mem_q[NL'(int'(m) + j)] <= res[j];
            end
            // A leaf decision is always followed by the g step of the deepest open node.
            if (lvl_q == '0) begin
                u_dec_q <= u_dec_nxt;
                leaf_q  <= leaf_nxt;
                lvl_q   <= ctz_nxt;
                g_q     <= 1'b1;
                if (last_step) u_hat_q <= u_dec_nxt;
            end else begin
                lvl_q <= lvl_q - NL'(1);
                g_q   <= 1'b0;
            end
        end
    end
endmodule
